// File: rtl/conv_pkg.sv
// Shared definitions for the K=3 convolutional encoder and its decoder:
// constraint length, default generator polynomials and frame FSM encoding.
package conv_pkg;

  localparam int K     = 3;
  localparam int CNT_W = 16;

  localparam logic [K-1:0] G0_DEFAULT = 3'b111;
  localparam logic [K-1:0] G1_DEFAULT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } enc_state_t;

endpackage

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with zero-tail frame termination and a
// single-register output slot under valid/ready flow control.
module conv_encoder
  import conv_pkg::*;
#(
  parameter int unsigned  FRAME_LEN = 8,
  parameter logic [K-1:0] G0        = G0_DEFAULT,
  parameter logic [K-1:0] G1        = G1_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       abort,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] bit_pair,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sof,
  output logic       eof
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  // MSB of the generator taps the current input u, LSB the oldest bit s[0].
  function automatic logic tap_xor(input logic [K-1:0] g, input logic [K-1:0] v);
    return ^(g & v);
  endfunction

  enc_state_t       state_q, state_d;
  logic [K-2:0]     s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tail_q, tail_d;
  logic [1:0]       pair_q, pair_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             run_q;
  logic             slot_free, accept, emit, u;

  assign slot_free = !valid_q || out_ready;
  // run_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = run_q && (state_q != ST_TAIL) && slot_free;
  assign accept    = in_valid && in_ready;

  assign bit_pair  = pair_q;
  assign out_valid = valid_q;
  assign sof       = sof_q;
  assign eof       = eof_q;

  always_comb begin
    // NOTE: every target gets a default first so no latch is inferred.
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    tail_d  = tail_q;
    pair_d  = pair_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    emit    = 1'b0;
    u       = 1'b0;

    if (slot_free) valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          emit  = 1'b1;
          u     = in_bit;
          sof_d = (state_q == ST_IDLE);
          eof_d = 1'b0;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            tail_d  = 1'b0;
            state_d = ST_TAIL;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_DATA;
          end
        end
      end
      ST_TAIL: begin
        // Flush two zeros so the trellis ends in state 00.
        if (slot_free) begin
          emit  = 1'b1;
          sof_d = 1'b0;
          eof_d = tail_q;
          if (tail_q) begin
            tail_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            tail_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      pair_d  = {tap_xor(G0, {u, s_q}), tap_xor(G1, {u, s_q})};
      s_d     = {u, s_q[K-2:1]};
      valid_d = 1'b1;
    end

    // Abort outranks any accept or tail generation in the same cycle.
    if (abort) begin
      state_d = ST_IDLE;
      s_d     = '0;
      cnt_d   = '0;
      tail_d  = 1'b0;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
    end
  end

  // NOTE: sequential state is assigned with <= so all registers sample together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      tail_q  <= 1'b0;
      pair_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      pair_q  <= pair_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed frames, stalls, abort, reset,
// FRAME_LEN=1 and randomized frames against a sequence-level reference model.
module tb_conv_encoder;

  localparam int         FL    = 4;
  localparam logic [2:0] POLY0 = 3'b111;
  localparam logic [2:0] POLY1 = 3'b101;

  logic       clk = 1'b0;
  logic       rst, abort, in_bit, in_valid, out_ready;
  logic       in_ready, out_valid, sof, eof;
  logic [1:0] bit_pair;

  logic       abort1, in1_bit, in1_valid, out1_ready;
  logic       in1_ready, out1_valid, sof1, eof1;
  logic [1:0] bit_pair1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] last_obs[$];
  // {pair, sof, eof} for frame 1,0,1,1: pairs 11,10,00,01,01,11.
  logic [3:0] ref_1011[6] = '{4'b1110, 4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b1101};

  always #5 clk = ~clk;

  conv_encoder #(.FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .abort(abort), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .bit_pair(bit_pair), .out_valid(out_valid),
    .out_ready(out_ready), .sof(sof), .eof(eof)
  );

  conv_encoder #(.FRAME_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .abort(abort1), .in_bit(in1_bit), .in_valid(in1_valid),
    .in_ready(in1_ready), .bit_pair(bit_pair1), .out_valid(out1_valid),
    .out_ready(out1_ready), .sof(sof1), .eof(eof1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {pair, sof, eof} for output i of an n-bit frame (MSB first) followed
  // by two zero tail bits, encoder starting from all-zero history.
  function automatic logic [3:0] model_entry(input logic [15:0] bits, input int n, input int i);
    logic [2:0] x;
    for (int k = 0; k < 3; k++) begin
      int j;
      j = i - k;
      x[2-k] = (j >= 0 && j < n) ? bits[n-1-j] : 1'b0;
    end
    return {^(x & POLY0), ^(x & POLY1), (i == 0), (i == n + 1)};
  endfunction

  // mode 0: always ready / always valid; 1: random ready and valid;
  // 2: downstream stalls 3 cycles while the 2nd pair is on the output.
  task automatic run_frame(input string tag, input logic [15:0] bits, input int mode);
    int         acc = 0;
    int         stall = 0;
    int         eof_iter = -1;
    logic       acc_prev = 1'b0;
    logic       done = 1'b0;
    logic       exp_rdy;
    logic [3:0] obs[$];
    for (int it = 0; it < 400 && !done; it++) begin
      @(negedge clk);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (obs.size() == 1 && stall < 3) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      #1;
      if (acc_prev) check({tag, ":latency"}, out_valid, 1);
      exp_rdy = (acc < FL || (obs.size() + int'(out_valid)) == FL + 2) &&
                (!out_valid || out_ready);
      check({tag, ":in_ready"}, in_ready, exp_rdy);
      if (mode == 2 && !out_ready) check({tag, ":hold"}, {out_valid, bit_pair}, 3'b110);
      if (out_valid && out_ready) begin
        obs.push_back({bit_pair, sof, eof});
        if (eof) begin
          done     = 1'b1;
          eof_iter = it;
        end
      end
      if (acc < FL && !done) in_valid = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      else                   in_valid = 1'b0;
      in_bit   = in_valid ? bits[FL-1-acc] : 1'($urandom_range(0, 1));
      acc_prev = in_valid && in_ready;
      if (acc_prev) acc++;
    end
    check({tag, ":eof_seen"}, done, 1);
    check({tag, ":count"}, obs.size(), FL + 2);
    for (int i = 0; i < obs.size() && i < FL + 2; i++)
      check({tag, ":pair"}, obs[i], model_entry(bits, FL, i));
    if (mode == 0) check({tag, ":throughput"}, eof_iter, FL + 2);
    last_obs = obs;
  endtask

  task automatic check_ref(input string tag);
    check({tag, ":ref_n"}, last_obs.size(), 6);
    for (int i = 0; i < 6 && i < last_obs.size(); i++)
      check({tag, ":ref"}, last_obs[i], ref_1011[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] q1[$];
    rst = 1'b0; abort = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    abort1 = 1'b0; in1_bit = 1'b0; in1_valid = 1'b0; out1_ready = 1'b1;

    // Reset state and in_ready release timing.
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", {in_ready, out_valid, bit_pair, sof, eof}, 0);
    check("reset_ready1", in1_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("ready_before_edge", in_ready, 0);
    @(negedge clk);
    #1 check("ready_after_edge", in_ready, 1);

    run_frame("r036", 16'b1011, 0);
    check_ref("r036");

    run_frame("r037", 16'b0000, 0);
    @(negedge clk);
    #1 check("r037:idle_ready", in_ready, 1);

    run_frame("r038", 16'b1011, 2);
    check_ref("r038");

    // Abort after two accepted bits, with a third bit offered during abort.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    in_bit = 1'b0;
    @(negedge clk);
    abort = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    #1 check("abort:valid", out_valid, 0);
    repeat (4) begin
      @(negedge clk);
      #1 check("abort:quiet", {out_valid, eof}, 0);
    end
    run_frame("r039", 16'b1011, 0);
    check_ref("r039");

    // Reset while the tail is being flushed.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("r040:reset_outs", {in_ready, out_valid, bit_pair, sof, eof}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame("r040", 16'b1011, 0);
    check_ref("r040");

    // FRAME_LEN=1: one bit gives sof pair and two tail pairs.
    @(negedge clk);
    in1_valid = 1'b1; in1_bit = 1'b1; out1_ready = 1'b1;
    #1 check("fl1:ready", in1_ready, 1);
    for (int it = 0; it < 8; it++) begin
      @(negedge clk);
      in1_valid = 1'b0;
      #1;
      if (out1_valid) q1.push_back({bit_pair1, sof1, eof1});
    end
    check("fl1:count", q1.size(), 3);
    if (q1.size() == 3) begin
      check("fl1:p0", q1[0], 4'b1110);
      check("fl1:p1", q1[1], 4'b1000);
      check("fl1:p2", q1[2], 4'b1101);
    end

    // Randomized frames with random handshakes and junk on invalid bits.
    for (int f = 0; f < 25; f++)
      run_frame("rand", 16'($urandom_range(0, 15)), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
